// File: rtl/mem_word_splitter_if.sv
// rtl/mem_word_splitter_if.sv - CPU word port and 16-bit PSRAM controller handshake bundle
interface mem_word_splitter_if #(
    parameter int ADDR_W = 26
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic              ram_mem;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;
    logic              ram_busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, ram_rdata, ram_busy,
        output cpu_rdata, cpu_ready, cpu_err, ram_mem, ram_rw, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, ram_rdata, ram_busy,
        input  cpu_rdata, cpu_ready, cpu_err, ram_mem, ram_rw, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_word_splitter.sv
// rtl/mem_word_splitter.sv - splits a 32-bit CPU access into low/high 16-bit PSRAM accesses
// Optional HALF_SKIP_EN: writes skip any half whose two byte enables are both clear.
module mem_word_splitter #(
    parameter int ADDR_W   = 26,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_word_splitter_if.slave bus
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LO_ISSUE = 3'd1,
        LO_WAIT  = 3'd2,
        HI_ISSUE = 3'd3,
        HI_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [15:0]       rwdata_q, rwdata_d;
`ifdef HALF_SKIP_EN
    logic [3:0]        be_q, be_d;
`else
    logic              unused_be;
    assign unused_be = ^bus.cpu_be;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            shadow_q <= '0;
            rdata_q  <= '0;
            rw_q     <= 1'b0;
            raddr_q  <= '0;
            rwdata_q <= '0;
`ifdef HALF_SKIP_EN
            be_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            rw_q     <= rw_d;
            raddr_q  <= raddr_d;
            rwdata_q <= rwdata_d;
`ifdef HALF_SKIP_EN
            be_q     <= be_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        rw_d     = rw_q;
        raddr_d  = raddr_q;
        rwdata_d = rwdata_q;
`ifdef HALF_SKIP_EN
        be_d     = be_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.cpu_req) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr[ADDR_W:2];
                    wdata_d = bus.cpu_wdata;
                    err_d   = 1'b0;
                    state_d = LO_ISSUE;
`ifdef HALF_SKIP_EN
                    be_d = bus.cpu_be;
                    if (bus.cpu_we && bus.cpu_be == 4'b0000) begin
                        state_d = DONE;
                    end else if (bus.cpu_we && bus.cpu_be[1:0] == 2'b00) begin
                        state_d = HI_ISSUE;
                    end
`endif
                end
            end
            LO_ISSUE: state_d = LO_WAIT;
            HI_ISSUE: state_d = HI_WAIT;
            LO_WAIT, HI_WAIT: begin
                if (!bus.ram_busy) begin
                    cnt_d = '0;
                    if (state_q == LO_WAIT) begin
                        if (!we_q) shadow_d = bus.ram_rdata;
                        state_d = HI_ISSUE;
`ifdef HALF_SKIP_EN
                        if (we_q && be_q[3:2] == 2'b00) state_d = DONE;
`endif
                    end else begin
                        // Publish the word now so it is already valid during the DONE pulse.
                        if (!we_q) rdata_d = {bus.ram_rdata, shadow_q};
                        state_d = DONE;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    cnt_d   = CNT_MAX;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Controller-facing fields are loaded on entry to an issue state and held through its wait.
        if (state_d == LO_ISSUE || state_d == HI_ISSUE) begin
            rw_d     = ~we_d;
            raddr_d  = {addr_d, state_d == HI_ISSUE};
            rwdata_d = (state_d == HI_ISSUE) ? wdata_d[31:16] : wdata_d[15:0];
        end
    end

    assign bus.ram_mem   = (state_q == LO_ISSUE) || (state_q == HI_ISSUE);
    assign bus.ram_rw    = rw_q;
    assign bus.ram_addr  = raddr_q;
    assign bus.ram_wdata = rwdata_q;
    assign bus.cpu_ready = (state_q == DONE);
    assign bus.cpu_err   = (state_q == DONE) && err_q;
    assign bus.cpu_rdata = rdata_q;
endmodule
